pool_window_gen: RTL and testbench

//  Raster-to-window converter feeding the 3x3 max-pooling stage. Accepts one

---
 rtl/pool_window_gen.sv | 138 +++++++++++++
 tb/tb_pool_window_gen.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/pool_window_gen.sv
// Raster-to-3x3-window generator feeding the max-pooling stage (two line buffers + 3x3 register window).
// Optional feature: define POOL_WIN_CNT_EN to add the win_cnt per-frame window counter output.
module pool_window_gen #(
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int STRIDE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  input  logic              sof_in,
  input  logic signed [7:0] pixel_in,
  output logic              valid_out,
  output logic signed [7:0] data_out0,
  output logic signed [7:0] data_out1,
  output logic signed [7:0] data_out2,
  output logic signed [7:0] data_out3,
  output logic signed [7:0] data_out4,
  output logic signed [7:0] data_out5,
  output logic signed [7:0] data_out6,
  output logic signed [7:0] data_out7,
  output logic signed [7:0] data_out8,
  output logic              frame_done
`ifdef POOL_WIN_CNT_EN
  ,
  output logic [15:0]       win_cnt
`endif
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0]     col_q, col_d, col_eff;
  logic [RW-1:0]     row_q, row_d, row_eff;
  logic signed [7:0] linebuf0_q [IMG_W];
  logic signed [7:0] linebuf1_q [IMG_W];
  logic signed [7:0] win_q  [9];
  logic signed [7:0] win_d  [9];
  logic signed [7:0] dout_q [9];
  logic              valid_q, frame_done_q;
  logic              accept, sof_eff, emit, last_px;

  function automatic logic on_grid(input int unsigned idx);
    return (idx >= 2) && (((idx - 2) % STRIDE) == 0);
  endfunction

  always_comb begin
    accept  = valid_in;
    sof_eff = valid_in & sof_in;
    row_eff = sof_eff ? '0 : row_q;
    col_eff = sof_eff ? '0 : col_q;
    last_px = (row_eff == ROW_LAST) && (col_eff == COL_LAST);
    emit    = on_grid(32'(row_eff)) && on_grid(32'(col_eff));

    // Shift the window left; the new right column is read top..bottom from the line buffers.
    for (int r = 0; r < 3; r++) begin
      win_d[3*r]   = win_q[3*r+1];
      win_d[3*r+1] = win_q[3*r+2];
    end
    win_d[2] = linebuf1_q[col_eff];
    win_d[5] = linebuf0_q[col_eff];
    win_d[8] = pixel_in;

    if (last_px) begin
      row_d = '0;
      col_d = '0;
    end else if (col_eff == COL_LAST) begin
      row_d = row_eff + 1'b1;
      col_d = '0;
    end else begin
      row_d = row_eff;
      col_d = col_eff + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q        <= '0;
      col_q        <= '0;
      valid_q      <= 1'b0;
      frame_done_q <= 1'b0;
      for (int k = 0; k < 9; k++) begin
        win_q[k]  <= '0;
        dout_q[k] <= '0;
      end
    end else begin
      valid_q      <= accept && emit;
      frame_done_q <= accept && last_px;
      if (accept) begin
        row_q <= row_d;
        col_q <= col_d;
        for (int k = 0; k < 9; k++) begin
          win_q[k] <= win_d[k];
          if (emit) dout_q[k] <= win_d[k];
        end
      end
    end
  end

  // Line buffers are plain RAM: never reset, stale rows are masked by the row>=2 gate.
  always_ff @(posedge clk) begin
    if (accept) begin
      linebuf1_q[col_eff] <= linebuf0_q[col_eff];
      linebuf0_q[col_eff] <= pixel_in;
    end
  end

`ifdef POOL_WIN_CNT_EN
  logic [15:0] win_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt_q <= '0;
    end else if (sof_eff || frame_done_q) begin
      win_cnt_q <= '0;
    end else if (accept && emit) begin
      win_cnt_q <= win_cnt_q + 16'd1;
    end
  end

  assign win_cnt = win_cnt_q;
`endif

  assign valid_out  = valid_q;
  assign frame_done = frame_done_q;
  assign data_out0  = dout_q[0];
  assign data_out1  = dout_q[1];
  assign data_out2  = dout_q[2];
  assign data_out3  = dout_q[3];
  assign data_out4  = dout_q[4];
  assign data_out5  = dout_q[5];
  assign data_out6  = dout_q[6];
  assign data_out7  = dout_q[7];
  assign data_out8  = dout_q[8];

endmodule

// File: tb/tb_pool_window_gen.sv
// Scoreboard bench for pool_window_gen: a 4x4/stride-1 and a 5x5/stride-2 instance driven by directed frames.
module tb_pool_window_gen;

  typedef struct packed {
    logic [71:0] d;
    logic        fd;
    logic [15:0] n;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n, sof_i, v4, v5;
  logic signed [7:0] pix;
  logic              vo4, fd4, vo5, fd5;
  logic signed [7:0] d4 [9];
  logic signed [7:0] d5 [9];
  logic [15:0]       wc4, wc5;
  logic              lastv4 = 1'b0, lastv5 = 1'b0, pfd4 = 1'b0, pfd5 = 1'b0;

  exp_t        q4[$];
  exp_t        q5[$];
  logic [7:0]  frame_pix [25];
  int          checks = 0;
  int          errors = 0;

  pool_window_gen #(.IMG_W(4), .IMG_H(4), .STRIDE(1)) dut4 (
    .clk(clk), .rst_n(rst_n), .valid_in(v4), .sof_in(sof_i), .pixel_in(pix),
    .valid_out(vo4),
    .data_out0(d4[0]), .data_out1(d4[1]), .data_out2(d4[2]),
    .data_out3(d4[3]), .data_out4(d4[4]), .data_out5(d4[5]),
    .data_out6(d4[6]), .data_out7(d4[7]), .data_out8(d4[8]),
    .frame_done(fd4)
`ifdef POOL_WIN_CNT_EN
    , .win_cnt(wc4)
`endif
  );

  pool_window_gen #(.IMG_W(5), .IMG_H(5), .STRIDE(2)) dut5 (
    .clk(clk), .rst_n(rst_n), .valid_in(v5), .sof_in(sof_i), .pixel_in(pix),
    .valid_out(vo5),
    .data_out0(d5[0]), .data_out1(d5[1]), .data_out2(d5[2]),
    .data_out3(d5[3]), .data_out4(d5[4]), .data_out5(d5[5]),
    .data_out6(d5[6]), .data_out7(d5[7]), .data_out8(d5[8]),
    .frame_done(fd5)
`ifdef POOL_WIN_CNT_EN
    , .win_cnt(wc5)
`endif
  );

`ifndef POOL_WIN_CNT_EN
  assign wc4 = 16'd0;
  assign wc5 = 16'd0;
`endif

  wire [71:0] act4 = {d4[0], d4[1], d4[2], d4[3], d4[4], d4[5], d4[6], d4[7], d4[8]};
  wire [71:0] act5 = {d5[0], d5[1], d5[2], d5[3], d5[4], d5[5], d5[6], d5[7], d5[8]};

  // Reference: window (r,c) element k is pixel ((r-2+k/3), (c-2+k%3)) of the raster in frame_pix.
  task automatic push_frame(input int sel, input int w, input int h, input int s);
    exp_t e;
    int   n = 0;
    for (int r = 2; r < h; r += s) begin
      for (int c = 2; c < w; c += s) begin
        n++;
        e.d  = '0;
        for (int k = 0; k < 9; k++)
          e.d[71-8*k -: 8] = frame_pix[(r - 2 + k / 3) * w + (c - 2 + k % 3)];
        e.fd = (r == h - 1) && (c == w - 1);
        e.n  = 16'(n);
        if (sel == 0) q4.push_back(e);
        else          q5.push_back(e);
      end
    end
  endtask

  task automatic drive(input int sel, input logic [7:0] px, input logic sof, input int gap);
    pix   = px;
    sof_i = sof;
    if (sel == 0) v4 = 1'b1;
    else          v5 = 1'b1;
    @(posedge clk); #1;
    v4    = 1'b0;
    v5    = 1'b0;
    sof_i = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic send_frame(input int sel, input int npix, input logic first_sof, input int gap);
    for (int i = 0; i < npix; i++)
      drive(sel, frame_pix[i], first_sof && (i == 0), gap);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", nm, act, req);
    end
  endtask

  task automatic check_dut(input int sel, input logic vo, input logic fd, input logic [71:0] act,
                           input logic lastv, input logic pfd, input logic [15:0] wc);
    exp_t  e;
    string nm = (sel == 0) ? "dut4" : "dut5";
    if (vo) begin
      chk({nm, "_valid_after_accept"}, 72'(lastv), 72'd1);
      if ((sel == 0 && q4.size() == 0) || (sel == 1 && q5.size() == 0)) begin
        checks++;
        errors++;
        $display("FAIL %s_unexpected_window: got data=%h required no window", nm, act);
      end else begin
        if (sel == 0) e = q4.pop_front();
        else          e = q5.pop_front();
        checks++;
        if (act !== e.d || fd !== e.fd) begin
          errors++;
          $display("FAIL %s_window%0d: got data=%h fd=%b required data=%h fd=%b",
                   nm, e.n, act, fd, e.d, e.fd);
        end else begin
          $display("%s window %0d data=%h frame_done=%b", nm, e.n, act, fd);
        end
`ifdef POOL_WIN_CNT_EN
        chk({nm, "_win_cnt"}, 72'(wc), 72'(e.n));
`endif
      end
    end else if (fd) begin
      chk({nm, "_frame_done_without_window"}, 72'(fd), 72'd0);
    end
`ifdef POOL_WIN_CNT_EN
    if (pfd) chk({nm, "_win_cnt_clear"}, 72'(wc), 72'd0);
`else
    if (pfd && wc != 16'd0) chk({nm, "_win_cnt_tie"}, 72'(wc), 72'd0);
`endif
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      check_dut(0, vo4, fd4, act4, lastv4, pfd4, wc4);
      check_dut(1, vo5, fd5, act5, lastv5, pfd5, wc5);
    end
    lastv4 <= v4;
    lastv5 <= v5;
    pfd4   <= fd4;
    pfd5   <= fd5;
  end

  initial begin
    rst_n = 1'b0; v4 = 1'b0; v5 = 1'b0; sof_i = 1'b0; pix = '0;
    #2;
    chk("reset_dut4_ctrl", 72'({vo4, fd4}), 72'd0);
    chk("reset_dut4_data", act4, 72'd0);
    chk("reset_dut5_ctrl", 72'({vo5, fd5}), 72'd0);
    chk("reset_dut5_data", act5, 72'd0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // Back-to-back 4x4 frame, pixels 0..15.
    for (int i = 0; i < 16; i++) frame_pix[i] = 8'(i);
    push_frame(0, 4, 4, 1);
    send_frame(0, 16, 1'b1, 0);
    idle(3);

    // 5x5 stride 2, pixels 0..24: centres 6, 8, 16, 18.
    for (int i = 0; i < 25; i++) frame_pix[i] = 8'(i);
    push_frame(1, 5, 5, 2);
    send_frame(1, 25, 1'b1, 0);
    idle(3);

    // Same 4x4 frame with valid_in pattern 1,0,0.
    for (int i = 0; i < 16; i++) frame_pix[i] = 8'(i);
    push_frame(0, 4, 4, 1);
    send_frame(0, 16, 1'b1, 2);
    idle(3);

    // Extreme values at the first window's corners.
    for (int i = 0; i < 16; i++) frame_pix[i] = 8'(i);
    frame_pix[0]  = 8'h80;
    frame_pix[2]  = 8'h7F;
    frame_pix[10] = 8'hFF;
    push_frame(0, 4, 4, 1);
    send_frame(0, 16, 1'b1, 0);
    idle(3);

    // Reset after 9 pixels of a frame, then a fresh frame without sof_in.
    for (int i = 0; i < 9; i++) frame_pix[i] = 8'(100 + i);
    send_frame(0, 9, 1'b1, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_dut4_ctrl", 72'({vo4, fd4}), 72'd0);
    chk("midreset_dut4_data", act4, 72'd0);
    idle(2);
    rst_n = 1'b1;
    idle(1);
    for (int i = 0; i < 16; i++) frame_pix[i] = 8'(i);
    push_frame(0, 4, 4, 1);
    send_frame(0, 16, 1'b0, 0);
    idle(3);

    // Abort after 7 pixels with sof_in, then a complete frame.
    for (int i = 0; i < 7; i++) frame_pix[i] = 8'(50 + i);
    send_frame(0, 7, 1'b1, 0);
    for (int i = 0; i < 16; i++) frame_pix[i] = 8'(i);
    push_frame(0, 4, 4, 1);
    send_frame(0, 16, 1'b1, 0);

    for (int i = 0; i < 50 && (q4.size() != 0 || q5.size() != 0); i++) idle(1);
    idle(2);
    chk("missing_windows", 72'(q4.size() + q5.size()), 72'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
